// File: rtl/mem_write_checker.sv
// Monitor on the core's data-memory write port: checks stores against a loadable
// table of expected (addr, data, mask) entries and latches a PASS/FAIL/TIMEOUT verdict.
module mem_write_checker #(
  parameter int WIDTH    = 32,
  parameter int NEXP     = 4,
  parameter int ORDERED  = 1,
  parameter int ALLOW_LO = 80,
  parameter int ALLOW_HI = 88,
  parameter int TIMEOUT  = 1024,
  localparam int IW  = (NEXP > 1) ? $clog2(NEXP) : 1,
  localparam int CNW = $clog2(NEXP + 1),
  localparam int CW  = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             start,
  input  logic             clr,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timed_out,
  output logic [CNW-1:0]   match_cnt,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data,
  output logic [CW-1:0]    cycles,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  localparam logic [WIDTH-1:0] WIN_LO = WIDTH'(ALLOW_LO);
  localparam logic [WIDTH-1:0] WIN_HI = WIDTH'(ALLOW_HI);

  state_t           state_q, state_d;
  logic [CNW-1:0]   match_cnt_q, match_cnt_d;
  logic [CW-1:0]    cycles_q, cycles_d, cycles_inc;
  logic [WIDTH-1:0] fail_addr_q, fail_addr_d, fail_data_q, fail_data_d;
  logic [NEXP-1:0]  matched_q, matched_d;
  logic [WIDTH-1:0] addr_q [NEXP];
  logic [WIDTH-1:0] addr_d [NEXP];
  logic [WIDTH-1:0] data_q [NEXP];
  logic [WIDTH-1:0] data_d [NEXP];
  logic [WIDTH-1:0] mask_q [NEXP];
  logic [WIDTH-1:0] mask_d [NEXP];

  logic          cand, hit_found, addr_hit, in_window;
  logic [IW-1:0] hit_idx;

  // Candidate search: ordered mode only looks at entry match_cnt, unordered at every
  // unmatched entry; the lowest-index match wins.
  always_comb begin
    cand      = 1'b0;
    hit_found = 1'b0;
    hit_idx   = '0;
    addr_hit  = 1'b0;
    for (int i = 0; i < NEXP; i++) begin
      cand = (ORDERED != 0) ? (match_cnt_q == CNW'(i)) : !matched_q[i];
      if (cand && dataadr == addr_q[i]) begin
        addr_hit = 1'b1;
        if (!hit_found && ((writedata & mask_q[i]) == (data_q[i] & mask_q[i]))) begin
          hit_found = 1'b1;
          hit_idx   = IW'(i);
        end
      end
    end
    in_window = (dataadr >= WIN_LO) && (dataadr <= WIN_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      match_cnt_q <= '0;
      cycles_q    <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      matched_q   <= '0;
      for (int i = 0; i < NEXP; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      cycles_q    <= cycles_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      matched_q   <= matched_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    cycles_d    = cycles_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    matched_d   = matched_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mask_d      = mask_q;
    cycles_inc  = (cycles_q == CW'(TIMEOUT)) ? cycles_q : cycles_q + 1'b1;
    if (clr) begin
      state_d     = S_IDLE;
      match_cnt_d = '0;
      cycles_d    = '0;
      fail_addr_d = '0;
      fail_data_d = '0;
      matched_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_we && (32'(cfg_idx) < NEXP)) begin
            addr_d[cfg_idx] = cfg_addr;
            data_d[cfg_idx] = cfg_data;
            mask_d[cfg_idx] = cfg_mask;
          end
          if (start) begin
            state_d     = S_RUN;
            cycles_d    = '0;
            match_cnt_d = '0;
            matched_d   = '0;
          end
        end
        S_RUN: begin
          cycles_d = cycles_inc;
          if (memwrite) begin
            if (hit_found) begin
              matched_d[hit_idx] = 1'b1;
              match_cnt_d        = match_cnt_q + 1'b1;
              if (match_cnt_q + 1'b1 == CNW'(NEXP)) state_d = S_PASS;
            end else if (addr_hit || !in_window) begin
              state_d     = S_FAIL;
              fail_addr_d = dataadr;
              fail_data_d = writedata;
            end
          end
          // A verdict reached on the same edge outranks the timeout.
          if (state_d == S_RUN && cycles_inc == CW'(TIMEOUT)) state_d = S_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pass      = (state_q == S_PASS);
    fail      = (state_q == S_FAIL);
    timed_out = (state_q == S_TIMEOUT);
    done      = pass | fail | timed_out;
    match_cnt = match_cnt_q;
    fail_addr = fail_addr_q;
    fail_data = fail_data_q;
    cycles    = cycles_q;
    dbg_state = state_q;
  end
endmodule
